instr_fetch_unit: RTL and testbench

// - Produces the 32-bit instruction word consumed by the instruction decoder; owns the PC.
// - Fetches from instruction memory over a req/valid handshake and holds each word until the decoder side accepts it.
// - Resolves next PC from the decoder's UncondBr / BrTaken / CondAddr19 / BrAddr26 outputs.
// - Sits between imem and instr_decoder in the single-cycle-issue datapath.

---
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/valid handshake and holds each word until accepted.
// Define IFU_PERF_CNT_EN to add the fetch_count / taken_count performance counters.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instruction,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] pc,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]       fetch_count,
    output logic [31:0]       taken_count,
`endif
    input  logic              UncondBr,
    input  logic              BrTaken,
    input  logic [18:0]       CondAddr19,
    input  logic [25:0]       BrAddr26,
    input  logic              halt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

    state_t            state_r;
    logic              accept_s;
    logic [ADDR_W-1:0] br_off_s;
    logic [ADDR_W-1:0] next_pc_s;

    // Word offsets are sign-extended and scaled to bytes; wrap-around is plain modulo arithmetic.
    function automatic logic [ADDR_W-1:0] word_off26(input logic [25:0] off);
        return {{(ADDR_W-28){off[25]}}, off, 2'b00};
    endfunction

    function automatic logic [ADDR_W-1:0] word_off19(input logic [18:0] off);
        return {{(ADDR_W-21){off[18]}}, off, 2'b00};
    endfunction

    assign accept_s  = (state_r == ST_HOLD) && instr_ready;
    assign imem_addr = {pc[ADDR_W-1:2], 2'b00};

    // Branch target selection; only consumed in the accept cycle.
    always_comb begin
        br_off_s  = word_off19(CondAddr19);
        next_pc_s = pc + PC_STEP;
        if (UncondBr) begin
            br_off_s = word_off26(BrAddr26);
        end else begin
            br_off_s = word_off19(CondAddr19);
        end
        if (BrTaken) begin
            next_pc_s = pc + br_off_s;
        end else begin
            next_pc_s = pc + PC_STEP;
        end
    end

    // Fetch FSM with registered handshake outputs, PC and held instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            pc          <= RESET_PC;
            instruction <= 32'h0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!halt) begin
                        state_r  <= ST_FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                        imem_req <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    // halt is deliberately ignored here: an outstanding request always completes.
                    if (imem_valid) begin
                        instruction <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state_r     <= ST_HOLD;
                    end else begin
                        imem_req    <= 1'b1;
                        state_r     <= ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (accept_s) begin
                        pc          <= next_pc_s;
                        instr_valid <= 1'b0;
                        if (halt) begin
                            state_r  <= ST_IDLE;
                            imem_req <= 1'b0;
                        end else begin
                            state_r  <= ST_FETCH;
                            imem_req <= 1'b1;
                        end
                    end else begin
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state_r     <= ST_HOLD;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    instr_valid <= 1'b0;
                    imem_req    <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFU_PERF_CNT_EN
    // Accept and taken-branch counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= 32'h0;
            taken_count <= 32'h0;
        end else begin
            if (accept_s) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (accept_s && BrTaken) begin
                taken_count <= taken_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a PC model pushes expected fetches, a monitor pops and compares.
module tb_instr_fetch_unit;

    localparam int          ADDR_W   = 64;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic              clk = 1'b0;
    logic              reset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic [31:0]       imem_rdata;
    logic [31:0]       instruction;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] pc;
    logic              UncondBr;
    logic              BrTaken;
    logic [18:0]       CondAddr19;
    logic [25:0]       BrAddr26;
    logic              halt;
`ifdef IFU_PERF_CNT_EN
    logic [31:0]       fetch_count;
    logic [31:0]       taken_count;
    int unsigned       m_fetch;
    int unsigned       m_taken;
`endif

    int          checks = 0;
    int          errors = 0;
    int          mode   = 0;
    logic [63:0] model_pc;
    logic [63:0] exp_q[$];
    logic [63:0] cur_pc;
    logic [31:0] cur_instr;
    logic        prev_valid  = 1'b0;
    logic        prev_accept = 1'b0;
    int          stall = 0;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .instruction(instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc),
`ifdef IFU_PERF_CNT_EN
        .fetch_count(fetch_count), .taken_count(taken_count),
`endif
        .UncondBr(UncondBr), .BrTaken(BrTaken),
        .CondAddr19(CondAddr19), .BrAddr26(BrAddr26), .halt(halt)
    );

    always #5 clk = ~clk;

    // Memory contents are a fixed hash of the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] h;
        h = a[33:2] * 32'h9E37_79B1;
        return h ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] ref_next(input logic [63:0] p, input logic taken,
                                             input logic unc, input logic [18:0] c19,
                                             input logic [25:0] b26);
        logic signed [25:0] s26;
        logic signed [18:0] s19;
        longint             off;
        s26 = b26;
        s19 = c19;
        if (!taken) return p + 64'd4;
        off = unc ? longint'(s26) : longint'(s19);
        return p + 64'(off * 4);
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 50; i++) begin
            if (instr_valid === 1'b1) return;
            @(posedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL %s: instr_valid not seen within 50 cycles", name);
    endtask

    task automatic accept(input logic tk, input logic unc, input logic [18:0] c19, input logic [25:0] b26);
        wait_valid("accept_wait");
        BrTaken = tk; UncondBr = unc; CondAddr19 = c19; BrAddr26 = b26;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0; BrTaken = 1'b0; UncondBr = 1'b0;
    endtask

    // Reference model: every accept determines the address of the next presented instruction.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            model_pc = RESET_PC;
            exp_q.push_back(RESET_PC);
`ifdef IFU_PERF_CNT_EN
            m_fetch = 0;
            m_taken = 0;
`endif
        end else if (instr_valid && instr_ready) begin
            model_pc = ref_next(model_pc, BrTaken, UncondBr, CondAddr19, BrAddr26);
            exp_q.push_back(model_pc);
`ifdef IFU_PERF_CNT_EN
            m_fetch++;
            if (BrTaken) m_taken++;
`endif
        end
    end

    // Monitor: pops on each new presentation and checks stability while held.
    always @(negedge clk) begin
        if (reset) begin
            check64("reset_valid", {63'h0, instr_valid}, 64'h0);
            check64("reset_req", {63'h0, imem_req}, 64'h0);
            check64("reset_pc", pc, RESET_PC);
            prev_valid  = 1'b0;
            prev_accept = 1'b0;
            stall       = 0;
        end else begin
            if (instr_valid) check64("req_in_hold", {63'h0, imem_req}, 64'h0);
            if (imem_req) check64("imem_addr", imem_addr, model_pc);
            if (instr_valid && !prev_valid) begin
                stall = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: pc 0x%0h presented, none expected", pc);
                end else begin
                    cur_pc    = exp_q.pop_front();
                    cur_instr = mem_word(cur_pc);
                    check64("pc", pc, cur_pc);
                    check64("instruction", {32'h0, instruction}, {32'h0, cur_instr});
                end
            end else if (instr_valid) begin
                check64("pc_stable", pc, cur_pc);
                check64("instr_stable", {32'h0, instruction}, {32'h0, cur_instr});
            end
            if (!instr_valid && prev_valid && !prev_accept) begin
                checks++;
                errors++;
                $display("FAIL valid_drop: instr_valid fell without instr_ready");
            end
            if (!instr_valid && !halt) stall++;
            if (stall > 100) begin
                checks++;
                errors++;
                $display("FAIL progress: no instruction within 100 cycles");
                stall = 0;
            end
            prev_valid  = instr_valid;
            prev_accept = instr_valid && instr_ready;
        end
    end

    // imem responder: 0 immediate, 1 random latency plus stray valids, 2 silent, 3 forced valid.
    initial begin
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk); #2;
            case (mode)
                0: begin
                    imem_valid = imem_req;
                    imem_rdata = imem_req ? mem_word(imem_addr) : 32'h0;
                end
                1: begin
                    if (imem_req) imem_valid = ($urandom % 2) == 0;
                    else          imem_valid = ($urandom % 4) == 0;
                    imem_rdata = (imem_req && imem_valid) ? mem_word(imem_addr) : 32'($urandom);
                end
                3: begin
                    imem_valid = 1'b1;
                    imem_rdata = 32'hDEAD_BEEF;
                end
                default: begin
                    imem_valid = 1'b0;
                    imem_rdata = 32'h0;
                end
            endcase
        end
    end

    initial begin
        reset = 1'b1; halt = 1'b0; instr_ready = 1'b0;
        BrTaken = 1'b0; UncondBr = 1'b0; CondAddr19 = 19'h0; BrAddr26 = 26'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Sequential fetches with an always-ready decoder: pc 0,4,8 every other cycle.
        instr_ready = 1'b1;
        wait_valid("seq_first");
        for (int k = 0; k < 3; k++) begin
            check64("seq_valid", {63'h0, instr_valid}, 64'h1);
            check64("seq_pc", pc, 64'(4 * k));
            @(posedge clk); #1;
            check64("seq_gap", {63'h0, instr_valid}, 64'h0);
            @(posedge clk); #1;
        end
        instr_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Branch resolution.
        accept(1'b1, 1'b1, 19'h0, 26'h0000040);
        wait_valid("uncond_fwd_wait");
        check64("uncond_fwd", pc, 64'h100);
        accept(1'b1, 1'b1, 19'h0, 26'h3FFFFFE);
        wait_valid("uncond_back_wait");
        check64("uncond_back", pc, 64'hF8);
        accept(1'b1, 1'b1, 19'h0, 26'h3FFFFD2);
        wait_valid("uncond_40_wait");
        check64("uncond_to_40", pc, 64'h40);
        accept(1'b1, 1'b0, 19'h00010, 26'h0);
        wait_valid("cond_wait");
        check64("cond_taken", pc, 64'h80);
        accept(1'b0, 1'b1, 19'h7FFFF, 26'h1234567);
        wait_valid("not_taken_wait");
        check64("not_taken", pc, 64'h84);

        // Backpressure: word and pc held, no new request.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check64("bp_valid", {63'h0, instr_valid}, 64'h1);
            check64("bp_pc", pc, 64'h84);
            check64("bp_req", {63'h0, imem_req}, 64'h0);
        end

        // Halt before accept parks in IDLE; release resumes at the updated pc.
        halt = 1'b1;
        accept(1'b0, 1'b0, 19'h0, 26'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check64("halt_req", {63'h0, imem_req}, 64'h0);
            check64("halt_valid", {63'h0, instr_valid}, 64'h0);
        end
        halt = 1'b0;
        wait_valid("halt_resume_wait");
        check64("halt_resume", pc, 64'h88);
`ifdef IFU_PERF_CNT_EN
        check64("perf_fetch", {32'h0, fetch_count}, 64'd6);
        check64("perf_taken", {32'h0, taken_count}, 64'd4);
`endif

        // Reset while a fetch is outstanding and imem_valid is high.
        mode = 2;
        instr_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (imem_req) break;
        end
        check64("rst_fetch_req", {63'h0, imem_req}, 64'h1);
        instr_ready = 1'b0;
        mode = 3;
        #2 reset = 1'b1;
        @(posedge clk); #1;
        check64("rst_valid", {63'h0, instr_valid}, 64'h0);
        check64("rst_pc", pc, RESET_PC);
        check64("rst_instr", {32'h0, instruction}, 64'h0);
        reset = 1'b0;
        mode = 0;
        wait_valid("rst_refetch_wait");
        check64("rst_refetch", {32'h0, instruction}, {32'h0, mem_word(RESET_PC)});

        // Randomized traffic against the model.
        mode = 1;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            reset       = ($urandom % 400) == 0;
            instr_ready = ($urandom % 10) < 7;
            halt        = ($urandom % 8) == 0;
            BrTaken     = ($urandom % 2) == 0;
            UncondBr    = ($urandom % 2) == 0;
            CondAddr19  = 19'($urandom);
            BrAddr26    = 26'($urandom);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        instr_ready = 1'b0;
        halt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
`ifdef IFU_PERF_CNT_EN
        check64("perf_fetch_rand", {32'h0, fetch_count}, {32'h0, m_fetch});
        check64("perf_taken_rand", {32'h0, taken_count}, {32'h0, m_taken});
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
